// File: rtl/shift_pkg.sv
// Shared encodings, widths and issue payload for the shift execution stage.
package shift_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned TYPE_W = 2;

  localparam logic [TYPE_W-1:0] SHIFT_LSL = 2'b00;
  localparam logic [TYPE_W-1:0] SHIFT_LSR = 2'b01;
  localparam logic [TYPE_W-1:0] SHIFT_ASR = 2'b10;
  localparam logic [TYPE_W-1:0] SHIFT_ROR = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic [TYPE_W-1:0] kind;
  } shift_op_t;

endpackage

// File: rtl/barrel_shifter32.sv
// Combinational 32-bit barrel shifter: LSL/LSR zero fill, ASR sign fill, ROR modulo 32.
module barrel_shifter32
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  logic [TYPE_W-1:0] type_i,
  output logic [DATA_W-1:0] result_c
);

  always_comb begin
    result_c = data_i;
    case (type_i)
      SHIFT_LSL: result_c = data_i << amt_i;
      SHIFT_LSR: result_c = data_i >> amt_i;
      SHIFT_ASR: result_c = DATA_W'($signed(data_i) >>> amt_i);
      // Rotate by shifting a doubled copy; amt 0 returns the operand unchanged.
      SHIFT_ROR: result_c = DATA_W'({data_i, data_i} >> amt_i);
      default:   result_c = data_i;
    endcase
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage shift execution pipeline (S1 operands, S2 result) with valid/ready handshakes.
// Optional retired-operation counter enabled by defining SHIFT_EXEC_PERF_CNT_EN.
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int unsigned RD_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic [4:0]        in_amt,
  input  logic [1:0]        in_type,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
  output logic [31:0]       perf_cnt
);

  logic              s1_valid_q, s1_valid_d;
  shift_op_t         s1_op_q, s1_op_d;
  logic [RD_W-1:0]   s1_rd_q, s1_rd_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [RD_W-1:0]   s2_rd_q, s2_rd_d;
  logic              s2_we_q, s2_we_d;
  logic [DATA_W-1:0] shift_res_c;
  logic              accept_c, advance_c, retire_c;

  barrel_shifter32 u_shifter (
    .data_i   (s1_op_q.data),
    .amt_i    (s1_op_q.amt),
    .type_i   (s1_op_q.kind),
    .result_c (shift_res_c)
  );

  assign in_ready  = !flush && (!s1_valid_q || !s2_valid_q || out_ready);
  assign accept_c  = in_valid && in_ready;
  assign advance_c = !flush && s1_valid_q && (!s2_valid_q || out_ready);
  assign retire_c  = !flush && s2_valid_q && out_ready;

  // Next-state for both stages; flush overrides any issue, advance or retire.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_rd_d    = s1_rd_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_rd_d    = s2_rd_q;
    s2_we_d    = s2_we_q;

    if (advance_c) begin
      s2_valid_d = 1'b1;
      s2_data_d  = shift_res_c;
      s2_rd_d    = s1_rd_q;
      s2_we_d    = (s1_rd_q != '0);
    end else if (retire_c) begin
      s2_valid_d = 1'b0;
    end

    if (accept_c) begin
      s1_valid_d   = 1'b1;
      s1_op_d.data = in_data;
      s1_op_d.amt  = in_amt;
      s1_op_d.kind = in_type;
      s1_rd_d      = in_rd;
    end else if (advance_c) begin
      s1_valid_d = 1'b0;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_rd_q    <= '0;
      s2_we_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_rd_q    <= s1_rd_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_rd_q    <= s2_rd_d;
      s2_we_q    <= s2_we_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_rd    = s2_rd_q;
  assign out_we    = s2_we_q;

`ifdef SHIFT_EXEC_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  // Counts retires outside flush cycles; wraps naturally at 2^32.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (retire_c) perf_cnt_d = perf_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_cnt_q <= '0;
    else        perf_cnt_q <= perf_cnt_d;
  end

  assign perf_cnt = perf_cnt_q;
`else
  assign perf_cnt = '0;
`endif

endmodule
